// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - Shared UART encodings: parity types, receive FSM states, parity helper.
package uart_pkg;

  localparam logic [1:0] PAR_EVEN  = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_MARK  = 2'b10;
  localparam logic [1:0] PAR_SPACE = 2'b11;

  typedef logic [2:0] uart_state_t;

  localparam uart_state_t S_IDLE   = 3'd0;
  localparam uart_state_t S_DATA   = 3'd1;
  localparam uart_state_t S_PARITY = 3'd2;
  localparam uart_state_t S_STOP1  = 3'd3;
  localparam uart_state_t S_STOP2  = 3'd4;
  localparam uart_state_t S_DONE   = 3'd5;

  // data_xor is the XOR of all received data bits
  function automatic logic expected_parity(input logic [1:0] typ, input logic data_xor);
    case (typ)
      PAR_EVEN: return data_xor;
      PAR_ODD:  return ~data_xor;
      PAR_MARK: return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_sat_counter.sv
// rtl/uart_sat_counter.sv - Saturating event counter with synchronous clear.
module uart_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  // clear has priority over a coincident increment
  always_ff @(posedge clk) begin
    if (!resetn || clr) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_frame_check.sv
// rtl/uart_frame_check.sv - UART receive frame assembly with parity and stop-bit checking.
// Define UART_FRAME_CHECK_ERR_CNT_EN to add saturating error counters and clr_cnt.
module uart_frame_check
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start_det,
  input  logic                  sample_strb,
  input  logic                  sampled_bit,
  input  logic                  PAR_EN,
  input  logic [1:0]            PAR_TYP,
  input  logic                  STOP2,
`ifdef UART_FRAME_CHECK_ERR_CNT_EN
  input  logic                  clr_cnt,
  output logic [CNT_WIDTH-1:0]  par_err_cnt,
  output logic [CNT_WIDTH-1:0]  stp_err_cnt,
`endif
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy
);

  localparam int BCW = $clog2(DATA_WIDTH + 1);

  if (DATA_WIDTH < 5 || DATA_WIDTH > 9 || CNT_WIDTH < 1) begin : g_param_check
    $error("uart_frame_check: DATA_WIDTH must be 5..9 and CNT_WIDTH at least 1");
  end

  uart_state_t           state;
  logic [BCW-1:0]        bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  run_par;
  logic                  par_flag;
  logic                  stp_flag;
  logic                  cfg_par_en;
  logic [1:0]            cfg_par_typ;
  logic                  cfg_stop2;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state       <= S_IDLE;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      run_par     <= 1'b0;
      par_flag    <= 1'b0;
      stp_flag    <= 1'b0;
      cfg_par_en  <= 1'b0;
      cfg_par_typ <= 2'b00;
      cfg_stop2   <= 1'b0;
      P_DATA      <= '0;
      data_valid  <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_det) begin
            state       <= S_DATA;
            busy        <= 1'b1;
            cfg_par_en  <= PAR_EN;
            cfg_par_typ <= PAR_TYP;
            cfg_stop2   <= STOP2;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            run_par     <= 1'b0;
            par_flag    <= 1'b0;
            stp_flag    <= 1'b0;
          end
        end
        S_DATA: begin
          if (sample_strb) begin
            // LSB arrives first, so shift in from the top
            shift_reg <= {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
            run_par   <= run_par ^ sampled_bit;
            bit_cnt   <= bit_cnt + BCW'(1);
            if (bit_cnt == BCW'(DATA_WIDTH - 1)) begin
              state <= cfg_par_en ? S_PARITY : S_STOP1;
            end
          end
        end
        S_PARITY: begin
          if (sample_strb) begin
            par_flag <= (sampled_bit != expected_parity(cfg_par_typ, run_par));
            state    <= S_STOP1;
          end
        end
        S_STOP1: begin
          if (sample_strb) begin
            if (!sampled_bit) begin
              stp_flag <= 1'b1;
            end
            state <= cfg_stop2 ? S_STOP2 : S_DONE;
          end
        end
        S_STOP2: begin
          if (sample_strb) begin
            if (!sampled_bit) begin
              stp_flag <= 1'b1;
            end
            state <= S_DONE;
          end
        end
        S_DONE: begin
          P_DATA     <= shift_reg;
          par_err    <= par_flag & cfg_par_en;
          stp_err    <= stp_flag;
          data_valid <= 1'b1;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef UART_FRAME_CHECK_ERR_CNT_EN
  logic in_done;
  assign in_done = (state == S_DONE);

  uart_sat_counter #(.WIDTH(CNT_WIDTH)) u_par_cnt (
    .clk    (CLK),
    .resetn (RST),
    .inc    (in_done & par_flag & cfg_par_en),
    .clr    (clr_cnt),
    .count  (par_err_cnt)
  );

  uart_sat_counter #(.WIDTH(CNT_WIDTH)) u_stp_cnt (
    .clk    (CLK),
    .resetn (RST),
    .inc    (in_done & stp_flag),
    .clr    (clr_cnt),
    .count  (stp_err_cnt)
  );
`endif

endmodule
